// File: rtl/psc_pkg.sv
// Shared definitions for the pattern stream controller: run states and the
// default pattern, also used by the detector bench.
package psc_pkg;

    typedef enum logic [2:0] {
        PSC_IDLE   = 3'd0,
        PSC_CLEAR  = 3'd1,
        PSC_STREAM = 3'd2,
        PSC_DRAIN  = 3'd3,
        PSC_DONE   = 3'd4
    } psc_state_e;

    localparam int                     PSC_PAT_LEN   = 20;
    localparam logic [PSC_PAT_LEN-1:0] PSC_PATTERN   = 20'b11001000010110110111;
    localparam int                     PSC_DRAIN_CYC = 2;
    localparam int                     PSC_CNT_W     = 5;

endpackage

// File: rtl/psc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module psc_sat_counter
    import psc_pkg::*;
#(
    parameter int CNT_W = PSC_CNT_W
) (
    input  logic             clk_1,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_stream_ctrl.sv
// Start/busy/done run controller that clears the sequence detector, streams a
// fixed pattern into it, drains it and counts hits. Optional: PSC_FIRST_HIT_EN.
module pattern_stream_ctrl
    import psc_pkg::*;
#(
    parameter int                 PAT_LEN   = PSC_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN   = PSC_PATTERN,
    parameter int                 DRAIN_CYC = PSC_DRAIN_CYC,
    parameter int                 CNT_W     = PSC_CNT_W
) (
    input  logic                       clk_1,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       det_hit,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       det_rst_n,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(PAT_LEN)-1:0] bit_idx,
    output logic [CNT_W-1:0]           hit_count
`ifdef PSC_FIRST_HIT_EN
    ,
    output logic [$clog2(PAT_LEN+DRAIN_CYC+1)-1:0] first_hit_idx,
    output logic                                   first_hit_vld
`endif
);

    localparam int IDX_W = $clog2(PAT_LEN);
    localparam int DR_W  = $clog2(DRAIN_CYC + 1);

    localparam logic [2:0] S_IDLE   = PSC_IDLE;
    localparam logic [2:0] S_CLEAR  = PSC_CLEAR;
    localparam logic [2:0] S_STREAM = PSC_STREAM;
    localparam logic [2:0] S_DRAIN  = PSC_DRAIN;
    localparam logic [2:0] S_DONE   = PSC_DONE;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PAT_LEN - 1);
    localparam logic [DR_W-1:0]  LAST_DRAIN = DR_W'(DRAIN_CYC - 1);

    logic [2:0]       state;
    logic [DR_W-1:0]  drain_cnt;
    logic [IDX_W-1:0] next_idx;
    logic             run_active;
    logic             abort_run;
    logic             enter_clear;
    logic             hit_inc;

    assign next_idx    = bit_idx + 1'b1;
    assign run_active  = (state == S_CLEAR) || (state == S_STREAM) || (state == S_DRAIN);
    assign abort_run   = abort && run_active;
    assign enter_clear = (state == S_IDLE) && start && !abort;
    // Hits only count while the detector sees pattern bits or is draining.
    assign hit_inc     = det_hit && !abort && ((state == S_STREAM) || (state == S_DRAIN));

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            det_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= '0;
            drain_cnt <= '0;
        end else if (abort_run) begin
            state     <= S_IDLE;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            det_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    det_rst_n <= 1'b1;
                    done      <= 1'b0;
                    if (enter_clear) begin
                        state     <= S_CLEAR;
                        det_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        bit_idx   <= '0;
                    end
                end
                S_CLEAR: begin
                    state     <= S_STREAM;
                    det_rst_n <= 1'b1;
                    bit_out   <= PATTERN[0];
                    bit_valid <= 1'b1;
                    bit_idx   <= '0;
                end
                S_STREAM: begin
                    if (bit_idx == LAST_IDX) begin
                        state     <= S_DRAIN;
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        bit_idx   <= '0;
                        drain_cnt <= '0;
                    end else begin
                        bit_idx <= next_idx;
                        bit_out <= PATTERN[next_idx];
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    psc_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk_1 (clk_1),
        .reset (reset),
        .clr   (enter_clear),
        .inc   (hit_inc),
        .count (hit_count)
    );

`ifdef PSC_FIRST_HIT_EN
    localparam int FH_W = $clog2(PAT_LEN + DRAIN_CYC + 1);

    // Offset counts from the first STREAM cycle and continues through DRAIN.
    logic [FH_W-1:0] hit_off;
    assign hit_off = (state == S_DRAIN) ? (FH_W'(PAT_LEN) + FH_W'(drain_cnt))
                                        : FH_W'(bit_idx);

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            first_hit_idx <= '0;
            first_hit_vld <= 1'b0;
        end else if (enter_clear) begin
            first_hit_idx <= '0;
            first_hit_vld <= 1'b0;
        end else if (hit_inc && !first_hit_vld) begin
            first_hit_idx <= hit_off;
            first_hit_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Directed bench for pattern_stream_ctrl: scoreboard of expected bits and run
// results, checked as the controller emits them.
module tb_pattern_stream_ctrl;

    localparam int PAT_LEN   = 20;
    localparam int DRAIN_CYC = 2;

    logic       clk_1 = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       det_hit;

    logic       bit_out, bit_valid, det_rst_n, busy, done;
    logic [4:0] bit_idx;
    logic [4:0] hit_count;
    logic       bit_out_b, bit_valid_b, det_rst_n_b, busy_b, done_b;
    logic [4:0] bit_idx_b;
    logic [3:0] hit_count_b;
`ifdef PSC_FIRST_HIT_EN
    logic [4:0] first_hit_idx, first_hit_idx_b;
    logic       first_hit_vld, first_hit_vld_b;
`endif

    pattern_stream_ctrl dut (
        .clk_1     (clk_1),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .det_hit   (det_hit),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .det_rst_n (det_rst_n),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx),
        .hit_count (hit_count)
`ifdef PSC_FIRST_HIT_EN
        ,
        .first_hit_idx (first_hit_idx),
        .first_hit_vld (first_hit_vld)
`endif
    );

    pattern_stream_ctrl #(.CNT_W(4)) dut_b (
        .clk_1     (clk_1),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .det_hit   (det_hit),
        .bit_out   (bit_out_b),
        .bit_valid (bit_valid_b),
        .det_rst_n (det_rst_n_b),
        .busy      (busy_b),
        .done      (done_b),
        .bit_idx   (bit_idx_b),
        .hit_count (hit_count_b)
`ifdef PSC_FIRST_HIT_EN
        ,
        .first_hit_idx (first_hit_idx_b),
        .first_hit_vld (first_hit_vld_b)
`endif
    );

    always #5 clk_1 = ~clk_1;

    typedef struct {
        logic       b;
        logic [4:0] idx;
    } bit_t;

    typedef struct {
        int cnt5;
        int cnt4;
        int fh_idx;
        int fh_vld;
    } res_t;

    bit_t bit_q[$];
    res_t res_q[$];
    bit   pat_bits [20] = '{1,1,1,0,1,1,0,1,1,0,1,0,0,0,0,1,0,0,1,1};
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hit_at(input int mode, input int o);
        case (mode)
            1:       return 1'b1;
            2:       return (o == 5) || (o == 12) || (o == 21);
            3:       return (o == 2) || (o == 4);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk_1);
        #1;
        if (bit_valid === 1'b1) begin
            chk("bit_expected", 32'(bit_q.size() != 0), 1);
            if (bit_q.size() != 0) begin
                bit_t e;
                e = bit_q.pop_front();
                chk("bit_out", bit_out, e.b);
                chk("bit_idx", bit_idx, e.idx);
                chk("busy_stream", busy, 1);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_expected", 32'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
                res_t r;
                r = res_q.pop_front();
                chk("hit_count", hit_count, r.cnt5);
                chk("hit_count_w4", hit_count_b, r.cnt4);
                chk("busy_done", busy, 0);
`ifdef PSC_FIRST_HIT_EN
                chk("first_hit_vld", first_hit_vld, r.fh_vld);
                if (r.fh_vld != 0) chk("first_hit_idx", first_hit_idx, r.fh_idx);
`endif
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bit_out"},   bit_out,     0);
        chk({tag, "_bit_valid"}, bit_valid,   0);
        chk({tag, "_det_rst_n"}, det_rst_n,   0);
        chk({tag, "_busy"},      busy,        0);
        chk({tag, "_done"},      done,        0);
        chk({tag, "_bit_idx"},   bit_idx,     0);
        chk({tag, "_hit_count"}, hit_count,   0);
        chk({tag, "_hit_cnt_b"}, hit_count_b, 0);
`ifdef PSC_FIRST_HIT_EN
        chk({tag, "_fh_vld"},    first_hit_vld, 0);
        chk({tag, "_fh_idx"},    first_hit_idx, 0);
`endif
    endtask

    // One run from IDLE; abort_off >= 0 aborts during that stream cycle.
    task automatic do_run(input int mode, input int abort_off, input bit spam);
        int last;
        int exp_cnt;
        int fh;
        int first_k;
        int done_k;
        int model_end;
        last      = (abort_off >= 0) ? abort_off : PAT_LEN - 1;
        model_end = (abort_off >= 0) ? abort_off - 1 : PAT_LEN + DRAIN_CYC - 1;
        for (int i = 0; i <= last; i++) bit_q.push_back('{pat_bits[i], 5'(i)});
        exp_cnt = 0;
        fh      = -1;
        for (int o = 0; o <= model_end; o++) begin
            if (hit_at(mode, o)) begin
                exp_cnt++;
                if (fh < 0) fh = o;
            end
        end
        if (abort_off < 0)
            res_q.push_back('{sat(exp_cnt, 5), sat(exp_cnt, 4), (fh < 0) ? 0 : fh, (fh >= 0) ? 1 : 0});

        det_hit = hit_at(mode, -2);
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_det_rst_n", det_rst_n, 0);
        chk("clear_hit_count", hit_count, 0);

        first_k = -1;
        done_k  = -1;
        for (int k = 1; k <= 40; k++) begin
            det_hit = hit_at(mode, k - 2);
            abort   = (abort_off >= 0) && (k - 2 == abort_off);
            start   = spam && ((k == 5) || (k == 15));
            tick();
            if ((bit_valid === 1'b1) && (first_k < 0)) first_k = k;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            if (abort) break;
        end
        det_hit = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        chk("first_bit_latency", first_k, 1);

        if (abort_off >= 0) begin
            chk("abort_busy", busy, 0);
            chk("abort_bit_valid", bit_valid, 0);
            chk("abort_det_rst_n", det_rst_n, 1);
            chk("abort_done", done, 0);
            chk("abort_hit_count", hit_count, exp_cnt);
`ifdef PSC_FIRST_HIT_EN
            chk("abort_fh_vld", first_hit_vld, (fh >= 0) ? 1 : 0);
            chk("abort_fh_idx", first_hit_idx, (fh >= 0) ? fh : 0);
`endif
        end else begin
            chk("done_latency", done_k, PAT_LEN + DRAIN_CYC + 1);
        end

        tick();
        chk("post_done_low", done, 0);
        chk("post_busy", busy, 0);
        tick();
        chk("post_idle_busy", busy, 0);
        chk("bit_q_empty", bit_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
    endtask

    initial begin
        int dc;
        int d1;
        int d2;
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        det_hit = 1'b0;
        #1;
        check_reset_vals("rst");
        tick();
        tick();
        chk("rst_held_det_rst_n", det_rst_n, 0);
        reset = 1'b1;
        tick();
        chk("rst_rel_det_rst_n", det_rst_n, 1);
        chk("rst_rel_busy", busy, 0);

        // Plain run, all hits, sparse hits.
        do_run(0, -1, 1'b0);
        do_run(1, -1, 1'b0);
        do_run(2, -1, 1'b0);

        // Abort mid-stream after two hits, then a fresh run clears the count.
        dc = done_cnt;
        do_run(3, 7, 1'b0);
        repeat (3) tick();
        chk("abort_no_done", done_cnt, dc);
        do_run(0, -1, 1'b0);

        // abort beats start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_det_rst_n", det_rst_n, 1);
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("idle_abort_busy2", busy, 0);

        // start pulses while busy are ignored.
        do_run(0, -1, 1'b1);

        // start held: back-to-back runs.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < PAT_LEN; i++) bit_q.push_back('{pat_bits[i], 5'(i)});
            res_q.push_back('{0, 0, 0, 0});
        end
        d1 = -1;
        d2 = -1;
        start = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("held_done_gap", d2 - d1, PAT_LEN + DRAIN_CYC + 3);
        tick();
        tick();
        chk("held_end_busy", busy, 0);
        chk("held_bit_q_empty", bit_q.size(), 0);
        chk("held_res_q_empty", res_q.size(), 0);

        // Reset in the middle of STREAM.
        for (int i = 0; i <= 10; i++) bit_q.push_back('{pat_bits[i], 5'(i)});
        start   = 1'b1;
        det_hit = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("pre_reset_hit_count", hit_count, 10);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        dc = done_cnt;
        tick();
        chk("midrst_held_det_rst_n", det_rst_n, 0);
        det_hit = 1'b0;
        reset   = 1'b1;
        tick();
        chk("midrst_rel_det_rst_n", det_rst_n, 1);
        chk("midrst_rel_busy", busy, 0);
        chk("midrst_rel_bit_valid", bit_valid, 0);
        repeat (30) tick();
        chk("midrst_no_done", done_cnt, dc);
        chk("midrst_bit_q_empty", bit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
